wb_i2c_slave: RTL and testbench

- I2C slave device with a Wishbone register port. On the I2C side it answers one fixed 7-bit device address and captures write bytes into an RX FIFO; on reads it returns a byte preloaded by software.
- On the Wishbone side a host reads status and RX data, loads TX data and gets an interrupt when a transfer completes.
- It sits on the same scl/sda bus as the iicmb I2C master and acts as the addressed target device.

---
 rtl/wb_i2c_slave.sv | 302 ++++++++++++++++++++++++++++++
 tb/tb_wb_i2c_slave.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_i2c_slave.sv
// wb_i2c_slave: I2C target device with a Wishbone register port.
//
// Answers one fixed 7-bit device address. Write bytes go into an RX FIFO
// (NACKed and dropped when the FIFO is full). Read data phases return the byte
// held in TXDATA, repeated for every byte the master asks for.
//
// Ports:
//   clk_i, rst_i          system clock, asynchronous active-low reset
//   cyc_i, stb_i, we_i    Wishbone cycle / strobe / write enable
//   adr_i, dat_i          Wishbone register address / write data
//   dat_o, ack_o          Wishbone read data / single-cycle acknowledge
//   irq                   level interrupt = done & irq_en
//   scl_i, sda_i          I2C bus inputs (asynchronous to clk_i)
//   sda_o                 open-drain SDA: 0 = pull low, 1 = release
//
// Registers: 0 STAT (RO), 1 RXDATA (RO, pops), 2 TXDATA (RW), 3 CTRL (RW).
module wb_i2c_slave #(
    parameter int         I2C_ADDR_WIDTH  = 7,
    parameter int         I2C_DATA_WIDTH  = 8,
    parameter logic [7:0] I2C_DEVICE_ADDR = 8'h22,
    parameter int         WB_ADDR_WIDTH   = 2,
    parameter int         WB_DATA_WIDTH   = 8,
    parameter int         RX_DEPTH        = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     cyc_i,
    input  logic                     stb_i,
    input  logic                     we_i,
    input  logic [WB_ADDR_WIDTH-1:0] adr_i,
    input  logic [WB_DATA_WIDTH-1:0] dat_i,
    output logic [WB_DATA_WIDTH-1:0] dat_o,
    output logic                     ack_o,
    output logic                     irq,
    input  logic                     scl_i,
    input  logic                     sda_i,
    output logic                     sda_o
);

    localparam int DW = I2C_DATA_WIDTH;
    localparam int CW = $clog2(DW + 1);
    localparam int PW = $clog2(RX_DEPTH);

    localparam logic [WB_ADDR_WIDTH-1:0] A_STAT = WB_ADDR_WIDTH'(0);
    localparam logic [WB_ADDR_WIDTH-1:0] A_RX   = WB_ADDR_WIDTH'(1);
    localparam logic [WB_ADDR_WIDTH-1:0] A_TX   = WB_ADDR_WIDTH'(2);
    localparam logic [WB_ADDR_WIDTH-1:0] A_CTRL = WB_ADDR_WIDTH'(3);

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE
    } state_t;

    // ------------------------------------------------------------------
    // Input conditioning: [1:0] synchronize, [2] holds the previous value
    // for edge detection. Reset to the idle-bus level so that leaving reset
    // does not look like bus activity.
    // ------------------------------------------------------------------
    logic [2:0] scl_s, sda_s;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            scl_s <= '1;
            sda_s <= '1;
        end else begin
            scl_s <= {scl_s[1:0], scl_i};
            sda_s <= {sda_s[1:0], sda_i};
        end
    end

    logic scl_c, scl_p, sda_c, sda_p;
    logic start_ev, stop_ev, scl_rise, scl_fall;

    assign scl_c    = scl_s[1];
    assign scl_p    = scl_s[2];
    assign sda_c    = sda_s[1];
    assign sda_p    = sda_s[2];
    // SCL must be high on both samples so a data change racing an SCL edge
    // is never mistaken for START/STOP.
    assign start_ev = scl_c & scl_p & sda_p & ~sda_c;
    assign stop_ev  = scl_c & scl_p & ~sda_p & sda_c;
    assign scl_rise = scl_c & ~scl_p;
    assign scl_fall = ~scl_c & scl_p;

    // ------------------------------------------------------------------
    // Shared state
    // ------------------------------------------------------------------
    state_t          state;
    logic [CW-1:0]   bit_cnt;
    logic [DW-1:0]   shreg;
    logic            phase;      // ack slot: first SCL fall already seen
    logic            ack_ok;     // write byte accepted -> drive ACK
    logic            rw;
    logic            xfer_act;   // address was ACKed, transfer in progress
    logic [2:0]      xfer_cnt;
    logic            busy;
    logic            op;
    logic [2:0]      last_cnt;

    logic [DW-1:0]   mem [RX_DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [PW:0]     fifo_cnt;
    logic            rx_empty, rx_full;

    logic [DW-1:0]   txdata;
    logic            en, irq_en, done;

    logic            req, wr_req, rd_req, pop, push, byte_done;
    logic            done_set, done_clr;
    logic [DW-1:0]   rx_byte;
    logic [7:0]      stat;
    logic [WB_DATA_WIDTH-1:0] rdata;

    assign rx_empty  = (fifo_cnt == '0);
    assign rx_full   = (fifo_cnt == (PW+1)'(RX_DEPTH));
    assign byte_done = scl_rise && (bit_cnt == CW'(DW - 1));
    assign rx_byte   = {shreg[DW-2:0], sda_c};

    assign req      = cyc_i & stb_i & ~ack_o;
    assign wr_req   = req & we_i;
    assign rd_req   = req & ~we_i;
    assign pop      = rd_req && (adr_i == A_RX) && !rx_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push     = en && (state == WR_DATA) && byte_done && (!rx_full || pop);
    assign done_set = en && xfer_act && (start_ev || stop_ev);
    assign done_clr = wr_req && (adr_i == A_CTRL) && dat_i[7];

    // ------------------------------------------------------------------
    // I2C protocol FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            shreg    <= '0;
            phase    <= 1'b0;
            ack_ok   <= 1'b0;
            rw       <= 1'b0;
            xfer_act <= 1'b0;
            xfer_cnt <= '0;
            busy     <= 1'b0;
            op       <= 1'b0;
            last_cnt <= '0;
            sda_o    <= 1'b1;
        end else if (!en) begin
            state    <= IDLE;
            busy     <= 1'b0;
            xfer_act <= 1'b0;
            sda_o    <= 1'b1;
        end else if (start_ev || stop_ev) begin
            if (xfer_act) begin
                op       <= rw;
                last_cnt <= xfer_cnt;
            end
            xfer_act <= 1'b0;
            xfer_cnt <= '0;
            bit_cnt  <= '0;
            sda_o    <= 1'b1;
            busy     <= start_ev;
            state    <= start_ev ? ADDR : IDLE;
        end else begin
            case (state)
                ADDR: if (scl_rise) begin
                    shreg   <= rx_byte;
                    bit_cnt <= bit_cnt + CW'(1);
                    if (byte_done) begin
                        rw <= sda_c;
                        if (shreg[I2C_ADDR_WIDTH-1:0] == I2C_DEVICE_ADDR[I2C_ADDR_WIDTH-1:0]) begin
                            state    <= ADDR_ACK;
                            phase    <= 1'b0;
                            xfer_act <= 1'b1;
                        end else begin
                            state <= IGNORE;
                        end
                    end
                end
                ADDR_ACK: if (scl_fall) begin
                    if (!phase) begin
                        sda_o <= 1'b0;
                        phase <= 1'b1;
                    end else if (rw) begin
                        // The fall ending the ACK slot is where bit 7 must appear.
                        state   <= RD_DATA;
                        sda_o   <= txdata[DW-1];
                        shreg   <= {txdata[DW-2:0], 1'b0};
                        bit_cnt <= CW'(1);
                    end else begin
                        state   <= WR_DATA;
                        sda_o   <= 1'b1;
                        bit_cnt <= '0;
                    end
                end
                WR_DATA: if (scl_rise) begin
                    shreg   <= rx_byte;
                    bit_cnt <= bit_cnt + CW'(1);
                    if (byte_done) begin
                        state  <= WR_ACK;
                        phase  <= 1'b0;
                        ack_ok <= push;
                        if (push && xfer_cnt != 3'd7)
                            xfer_cnt <= xfer_cnt + 3'd1;
                    end
                end
                WR_ACK: if (scl_fall) begin
                    if (!phase) begin
                        sda_o <= ~ack_ok;
                        phase <= 1'b1;
                    end else begin
                        sda_o   <= 1'b1;
                        state   <= WR_DATA;
                        bit_cnt <= '0;
                    end
                end
                RD_DATA: if (scl_fall) begin
                    if (bit_cnt == CW'(DW)) begin
                        sda_o <= 1'b1;
                        state <= RD_ACK;
                        if (xfer_cnt != 3'd7)
                            xfer_cnt <= xfer_cnt + 3'd1;
                    end else begin
                        sda_o   <= shreg[DW-1];
                        shreg   <= {shreg[DW-2:0], 1'b0};
                        bit_cnt <= bit_cnt + CW'(1);
                    end
                end
                RD_ACK: if (scl_rise) begin
                    if (!sda_c) begin
                        state   <= RD_DATA;
                        shreg   <= txdata;
                        bit_cnt <= '0;
                    end else begin
                        state <= IGNORE;
                    end
                end
                default: sda_o <= 1'b1;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // RX FIFO
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < RX_DEPTH; i++) mem[i] <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= rx_byte;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + (PW+1)'(1);
                2'b01:   fifo_cnt <= fifo_cnt - (PW+1)'(1);
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Wishbone registers
    // ------------------------------------------------------------------
    assign stat = {last_cnt, busy, rx_full, ~rx_empty, op, done};

    always_comb begin
        rdata = '0;
        case (adr_i)
            A_STAT:  rdata = WB_DATA_WIDTH'(stat);
            A_RX:    rdata = rx_empty ? '0 : WB_DATA_WIDTH'(mem[rd_ptr]);
            A_TX:    rdata = WB_DATA_WIDTH'(txdata);
            A_CTRL:  rdata = WB_DATA_WIDTH'({irq_en, en});
            default: rdata = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ack_o  <= 1'b0;
            dat_o  <= '0;
            txdata <= '0;
            en     <= 1'b0;
            irq_en <= 1'b0;
            done   <= 1'b0;
        end else begin
            ack_o <= req;
            if (req) dat_o <= rdata;
            if (wr_req && adr_i == A_TX) txdata <= dat_i[DW-1:0];
            if (wr_req && adr_i == A_CTRL) begin
                en     <= dat_i[0];
                irq_en <= dat_i[1];
            end
            // A transfer ending in the same cycle as a clear keeps done set.
            if (done_set)      done <= 1'b1;
            else if (done_clr) done <= 1'b0;
        end
    end

    assign irq = done & irq_en;

endmodule

// File: tb/tb_wb_i2c_slave.sv
// Self-checking bench for wb_i2c_slave: a bit-level I2C master drives the bus,
// a transaction-level model (byte queue + done/op/count flags) predicts STAT,
// RXDATA, ACK/NACK answers and read data.
module tb_wb_i2c_slave;
    localparam int         RX_DEPTH = 4;
    localparam int         Q        = 8;      // clocks per quarter SCL period
    localparam logic [6:0] DEV      = 7'h22;

    logic       clk_i = 1'b0, rst_i = 1'b1;
    logic       cyc_i = 1'b0, stb_i = 1'b0, we_i = 1'b0;
    logic [1:0] adr_i = '0;
    logic [7:0] dat_i = '0;
    logic [7:0] dat_o;
    logic       ack_o, irq, sda_o;
    logic       scl_m = 1'b1, sda_m = 1'b1;
    logic       scl_i, sda_i;

    assign scl_i = scl_m;
    assign sda_i = sda_m & sda_o;   // wired-AND open-drain bus

    wb_i2c_slave dut (
        .clk_i(clk_i), .rst_i(rst_i), .cyc_i(cyc_i), .stb_i(stb_i), .we_i(we_i),
        .adr_i(adr_i), .dat_i(dat_i), .dat_o(dat_o), .ack_o(ack_o), .irq(irq),
        .scl_i(scl_i), .sda_i(sda_i), .sda_o(sda_o)
    );

    always #5 clk_i = ~clk_i;

    int tests = 0, fails = 0;

    // reference model
    logic [7:0] q[$];
    logic       m_done = 1'b0, m_op = 1'b0;
    int         m_cnt = 0;
    logic [7:0] m_tx = '0;
    logic [7:0] wdata[8];

    // counts cycles where the slave pulls SDA while watched
    logic watch = 1'b0;
    int   low_cnt = 0;
    always @(negedge clk_i) if (watch && sda_o == 1'b0) low_cnt <= low_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_stat(input logic b);
        int n = q.size();
        logic [2:0] c = (m_cnt > 7) ? 3'd7 : 3'(m_cnt);
        return {c, b, n == RX_DEPTH, n != 0, m_op, m_done};
    endfunction

    task automatic wb_xfer(input logic w, input logic [1:0] a, input logic [7:0] d,
                           output logic [7:0] r);
        int n = 0;
        @(posedge clk_i); #1;
        cyc_i = 1'b1; stb_i = 1'b1; we_i = w; adr_i = a; dat_i = d;
        do begin @(posedge clk_i); #1; n++; end while (!ack_o && n < 8);
        chk("wb_ack", ack_o, 1'b1);
        r = dat_o;
        cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
        @(posedge clk_i); #1;
        chk("wb_ack_one_cycle", ack_o, 1'b0);
    endtask

    task automatic wb_rd(input logic [1:0] a, output logic [7:0] r);
        wb_xfer(1'b0, a, 8'h00, r);
    endtask

    task automatic wb_wr(input logic [1:0] a, input logic [7:0] d);
        logic [7:0] r;
        wb_xfer(1'b1, a, d, r);
    endtask

    task automatic qwait();
        repeat (Q) @(posedge clk_i);
        #1;
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; qwait(); scl_m = 1'b1; qwait();
        sda_m = 1'b0; qwait(); scl_m = 1'b0; qwait();
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; qwait(); scl_m = 1'b1; qwait(); sda_m = 1'b1; qwait();
    endtask

    task automatic wbit(input logic b);
        sda_m = b; qwait(); scl_m = 1'b1; qwait(); qwait(); scl_m = 1'b0; qwait();
    endtask

    task automatic rbit(output logic b);
        sda_m = 1'b1; qwait(); scl_m = 1'b1; qwait(); b = sda_i; qwait(); scl_m = 1'b0; qwait();
    endtask

    task automatic wbyte(input logic [7:0] v, output logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) wbit(v[i]);
        rbit(b);
        ack = ~b;
    endtask

    task automatic rbyte(output logic [7:0] v, input logic mack);
        logic b;
        v = '0;
        for (int i = 7; i >= 0; i--) begin rbit(b); v = {v[6:0], b}; end
        wbit(~mack);
    endtask

    // Complete write transfer of wdata[0..n-1]; the model decides each answer.
    task automatic i2c_write(input logic [7:0] addr, input int n);
        logic a, match, exp_a;
        int acked = 0;
        match = (addr[7:1] == DEV) && !addr[0];
        i2c_start();
        wbyte(addr, a);
        chk("addr_ack", a, match);
        for (int i = 0; i < n; i++) begin
            wbyte(wdata[i], a);
            exp_a = match && (q.size() < RX_DEPTH);
            chk("data_ack", a, exp_a);
            if (exp_a) begin q.push_back(wdata[i]); acked++; end
        end
        i2c_stop();
        if (match) begin m_done = 1'b1; m_op = 1'b0; m_cnt = acked; end
    endtask

    initial begin
        logic [7:0] r, v, a8;
        logic       a;
        int         lows;

        // ---- reset state
        #1 rst_i = 1'b0;
        #1;
        chk("rst_ack", ack_o, 1'b0);
        chk("rst_dat", dat_o, 8'h00);
        chk("rst_irq", irq, 1'b0);
        chk("rst_sda", sda_o, 1'b1);
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wb_rd(2'(i), r);
            chk("rst_reg", r, 8'h00);
        end

        // ---- single-byte write, 0x78
        wb_wr(2'd3, 8'h03);
        wdata[0] = 8'h78;
        i2c_write(8'h44, 1);
        wb_rd(2'd0, r); chk("stat_wr1", r, exp_stat(1'b0));
        chk("irq_set", irq, 1'b1);
        wb_rd(2'd1, r); chk("rx_pop", r, q.pop_front());
        wb_rd(2'd0, r); chk("stat_after_pop", r, exp_stat(1'b0));
        wb_wr(2'd3, 8'h83); m_done = 1'b0;
        chk("irq_clr", irq, 1'b0);
        wb_rd(2'd3, r); chk("ctrl_rb", r, 8'h03);

        // ---- wrong address: never driven, no done
        lows = low_cnt;
        watch = 1'b1;
        wdata[0] = 8'($urandom);
        i2c_write(8'h46, 1);
        watch = 1'b0;
        chk("nack_sda_low", low_cnt - lows, 0);
        wb_rd(2'd0, r); chk("stat_nack", r, exp_stat(1'b0));

        // ---- read two bytes of TXDATA
        m_tx = 8'($urandom);
        wb_wr(2'd2, m_tx);
        wb_rd(2'd2, r); chk("txdata_rb", r, m_tx);
        i2c_start();
        wbyte(8'h45, a); chk("rd_addr_ack", a, 1'b1);
        rbyte(v, 1'b1); chk("rd_byte0", v, m_tx);
        rbyte(v, 1'b0); chk("rd_byte1", v, m_tx);
        wb_rd(2'd0, r); chk("stat_busy", r, exp_stat(1'b1));
        i2c_stop();
        m_done = 1'b1; m_op = 1'b1; m_cnt = 2;
        wb_rd(2'd0, r); chk("stat_rd", r, exp_stat(1'b0));
        wb_wr(2'd3, 8'h83); m_done = 1'b0;

        // ---- overflow: six bytes into a four-entry FIFO
        for (int i = 0; i < 6; i++) wdata[i] = 8'($urandom);
        i2c_write(8'h44, 6);
        wb_rd(2'd0, r); chk("stat_full", r, exp_stat(1'b0));
        chk("irq_full", irq, 1'b1);
        while (q.size() != 0) begin
            wb_rd(2'd1, r); chk("rx_drain", r, q.pop_front());
        end
        wb_rd(2'd1, r); chk("rx_empty_read", r, 8'h00);
        wb_rd(2'd0, r); chk("stat_drained", r, exp_stat(1'b0));

        // ---- reset while the slave drives the address ACK
        i2c_start();
        a8 = 8'h44;
        for (int i = 7; i >= 0; i--) wbit(a8[i]);
        chk("ack_drive_pre_rst", sda_o, 1'b0);
        chk("irq_pre_rst", irq, 1'b1);
        rst_i = 1'b0;
        #1;
        chk("mid_rst_ack", ack_o, 1'b0);
        chk("mid_rst_dat", dat_o, 8'h00);
        chk("mid_rst_irq", irq, 1'b0);
        chk("mid_rst_sda", sda_o, 1'b1);
        q.delete(); m_done = 1'b0; m_op = 1'b0; m_cnt = 0;
        scl_m = 1'b1; sda_m = 1'b1;
        qwait();
        rst_i = 1'b1;
        qwait();
        wb_rd(2'd0, r); chk("stat_post_rst", r, exp_stat(1'b0));
        wb_wr(2'd3, 8'h03);
        wdata[0] = 8'($urandom);
        wdata[1] = 8'($urandom);
        i2c_write(8'h44, 2);
        wb_rd(2'd0, r); chk("stat_post_rst_wr", r, exp_stat(1'b0));
        while (q.size() != 0) begin
            wb_rd(2'd1, r); chk("rx_post_rst", r, q.pop_front());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
